// File: rtl/node_rec_arbiter.sv
// ---------------------------------------------------------------------------
// node_rec_arbiter
// Round-robin scheduler for the packed CAN receive-flag vector. One bus with a
// pending received message is granted the shared receive/readout path; the
// grant is held until the reader pulses rec_done or a timeout forces release.
// A one-cycle RELEASE gap follows every grant so the served node can clear
// its flag before the next arbitration round.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   can_rec     in   [N_BUS-1:0] level request per bus
//   bus_en      in   [N_BUS-1:0] per-bus enable mask
//   rec_done    in   reader pulse: granted message consumed
//   rec_valid   out  grant active, bus_id/rec_sel valid
//   bus_id      out  [4:0] index of the granted bus (held after release)
//   rec_sel     out  [N_BUS-1:0] one-hot of bus_id while rec_valid
//   arb_busy    out  high in any state other than IDLE
//   timeout_err out  one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module node_rec_arbiter #(
  parameter int N_BUS       = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TIMEOUT_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BUS-1:0] can_rec,
  input  logic [N_BUS-1:0] bus_en,
  input  logic             rec_done,
  output logic             rec_valid,
  output logic [4:0]       bus_id,
  output logic [N_BUS-1:0] rec_sel,
  output logic             arb_busy,
  output logic             timeout_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [N_BUS-1:0]     SEL_ONE  = {{(N_BUS-1){1'b0}}, 1'b1};

  logic [1:0]           state_r;
  logic [1:0]           state_nxt_s;
  logic [4:0]           rr_ptr_r;
  logic [4:0]           rr_ptr_nxt_s;
  logic [TIMEOUT_W-1:0] tmo_cnt_r;
  logic [TIMEOUT_W-1:0] tmo_cnt_nxt_s;
  logic [4:0]           bus_id_nxt_s;
  logic                 tmo_err_nxt_s;
  logic [N_BUS-1:0]     req_r;
  logic [4:0]           pick_s;

  // Round-robin search: walk downward so the lowest offset from rr_ptr wins.
  always_comb begin
    logic [4:0] idx;
    idx    = 5'd0;
    pick_s = 5'd0;
    for (int i = N_BUS - 1; i >= 0; i--) begin
      idx = rr_ptr_r + 5'(i);
      if (req_r[idx]) begin
        pick_s = idx;
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // Next-state, pointer, timeout counter and grant-index computation.
  always_comb begin
    state_nxt_s   = state_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    tmo_cnt_nxt_s = tmo_cnt_r;
    bus_id_nxt_s  = bus_id;
    tmo_err_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmo_cnt_nxt_s = {TIMEOUT_W{1'b0}};
        if (|req_r) begin
          bus_id_nxt_s = pick_s;
          state_nxt_s  = ST_GRANT;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // rec_done has priority over a coincident timeout
        if (rec_done) begin
          state_nxt_s   = ST_RELEASE;
          rr_ptr_nxt_s  = bus_id + 5'd1;
          tmo_cnt_nxt_s = {TIMEOUT_W{1'b0}};
        end else if (tmo_cnt_r == TMO_LAST) begin
          state_nxt_s   = ST_RELEASE;
          rr_ptr_nxt_s  = bus_id + 5'd1;
          tmo_cnt_nxt_s = {TIMEOUT_W{1'b0}};
          tmo_err_nxt_s = 1'b1;
        end else begin
          tmo_cnt_nxt_s = tmo_cnt_r + TIMEOUT_W'(1);
        end
      end
      ST_RELEASE: begin
        state_nxt_s   = ST_IDLE;
        tmo_cnt_nxt_s = {TIMEOUT_W{1'b0}};
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        tmo_cnt_nxt_s = {TIMEOUT_W{1'b0}};
      end
    endcase
  end

  // State registers; outputs are registered from the next-state values so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= 5'd0;
      tmo_cnt_r   <= {TIMEOUT_W{1'b0}};
      req_r       <= {N_BUS{1'b0}};
      bus_id      <= 5'd0;
      rec_valid   <= 1'b0;
      rec_sel     <= {N_BUS{1'b0}};
      arb_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
      req_r       <= can_rec & bus_en;
      bus_id      <= bus_id_nxt_s;
      rec_valid   <= (state_nxt_s == ST_GRANT);
      rec_sel     <= (state_nxt_s == ST_GRANT) ? (SEL_ONE << bus_id_nxt_s) : {N_BUS{1'b0}};
      arb_busy    <= (state_nxt_s != ST_IDLE);
      timeout_err <= tmo_err_nxt_s;
    end
  end

endmodule
